// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified RAM plus LED/timer MMIO responder for the CPU memory port
module mem_responder #(
    parameter int DEPTH_WORDS = 2048,
    parameter     INIT_FILE   = "",
    parameter int CLK_HZ      = 12000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_wen,
    input  logic [31:0] mem_wa,
    input  logic [31:0] mem_wd,
    input  logic [31:0] mem_ra,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_rd,
    output logic [7:0]  leds,
    output logic        misaligned_err
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] PRE_LAST  = 32'(CLK_HZ / 1000000 - 1);
    localparam logic [29:0] LED_WORD  = 30'h3FFF_FFFF;
    localparam logic [29:0] MS_WORD   = 30'h3FFF_FFFE;
    localparam logic [29:0] US_WORD   = 30'h3FFF_FFFD;

    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_t;

    logic [31:0] ram [DEPTH_WORDS];

    // funct3[1:0] gives the access size (11 falls into word), funct3[2] marks unsigned loads
    logic [1:0]    size;
    logic          ra_mis, wa_mis, ra_ram, wa_ram, wr_ok;
    logic          mmio_hit;
    logic [31:0]   mmio_val;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [AW-1:0] ra_idx, wa_idx;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    assign size   = mem_funct3[1:0];
    assign ra_mis = misaligned(size, mem_ra[1:0]);
    assign wa_mis = misaligned(size, mem_wa[1:0]);
    assign ra_ram = mem_ra[31:AW+2] == '0;
    assign wa_ram = mem_wa[31:AW+2] == '0;
    assign ra_idx = mem_ra[AW+1:2];
    assign wa_idx = mem_wa[AW+1:2];
    assign wr_ok  = reset_n && mem_wen && !wa_mis;

    always_comb begin
        be    = 4'b1111;
        wdata = mem_wd;
        case (size)
            2'b00: begin
                be    = 4'b0001 << mem_wa[1:0];
                wdata = {4{mem_wd[7:0]}};
            end
            2'b01: begin
                be    = mem_wa[1] ? 4'b1100 : 4'b0011;
                wdata = {2{mem_wd[15:0]}};
            end
            default: ;
        endcase
    end

    logic [31:0] micros, millis, prescaler;
    logic [9:0]  us_in_ms;

    always_comb begin
        mmio_hit = 1'b1;
        mmio_val = 32'h0;
        case (mem_ra[31:2])
            LED_WORD: mmio_val = {24'h0, leds};
            MS_WORD:  mmio_val = millis;
            US_WORD:  mmio_val = micros;
            default:  mmio_hit = 1'b0;
        endcase
    end

    // Read-first: the registered read sees the word before this edge's write lands
    logic [31:0] ram_q, mmio_q;

    always_ff @(posedge clk) begin
        ram_q  <= ram[ra_idx];
        mmio_q <= mmio_val;
        if (wr_ok && wa_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[wa_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    src_t       r_src;
    logic [1:0] r_off, r_size;
    logic       r_signed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_src          <= SRC_NONE;
            r_off          <= 2'b00;
            r_size         <= 2'b10;
            r_signed       <= 1'b0;
            leds           <= 8'h0;
            misaligned_err <= 1'b0;
            prescaler      <= 32'h0;
            us_in_ms       <= 10'd0;
            micros         <= 32'h0;
            millis         <= 32'h0;
        end else begin
            r_off    <= mem_ra[1:0];
            r_size   <= size;
            r_signed <= !mem_funct3[2];
            if (ra_mis)        r_src <= SRC_NONE;
            else if (ra_ram)   r_src <= SRC_RAM;
            else if (mmio_hit) r_src <= SRC_MMIO;
            else               r_src <= SRC_NONE;

            if (ra_mis || (mem_wen && wa_mis)) misaligned_err <= 1'b1;
            if (wr_ok && mem_wa[31:2] == LED_WORD && be[0]) leds <= wdata[7:0];

            if (prescaler == PRE_LAST) begin
                prescaler <= 32'h0;
                micros    <= micros + 32'd1;
                if (us_in_ms == 10'd999) begin
                    us_in_ms <= 10'd0;
                    millis   <= millis + 32'd1;
                end else begin
                    us_in_ms <= us_in_ms + 10'd1;
                end
            end else begin
                prescaler <= prescaler + 32'd1;
            end
        end
    end

    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        case (r_src)
            SRC_RAM:  word = ram_q;
            SRC_MMIO: word = mmio_q;
            default:  word = 32'h0;
        endcase
        bsel = word[{r_off, 3'b000} +: 8];
        hsel = r_off[1] ? word[31:16] : word[15:0];
        case (r_size)
            2'b00:   mem_rd = {{24{r_signed & bsel[7]}}, bsel};
            2'b01:   mem_rd = {{16{r_signed & hsel[15]}}, hsel};
            default: mem_rd = word;
        endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder RAM, MMIO and timers
module tb_mem_responder;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_wa = 32'h0, mem_wd = 32'h0, mem_ra = 32'h0;
    logic [2:0]  mem_funct3 = 3'b010;
    logic [31:0] mem_rd;
    logic [7:0]  leds;
    logic        misaligned_err;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(2048), .INIT_FILE(""), .CLK_HZ(2000000)) dut (
        .clk(clk), .reset_n(reset_n), .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_funct3(mem_funct3), .mem_rd(mem_rd), .leds(leds),
        .misaligned_err(misaligned_err)
    );

    int          n_cmp = 0, n_bad = 0, rd_no = 0;
    logic [31:0] exp_q[$];
    int          tol_q[$];
    int          tag_q[$];
    logic        chk_issue = 1'b0;
    logic        mon_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a read issued before a posedge is compared at the following negedge
    always begin
        logic [31:0] e;
        int          t, g;
        logic        ok;
        @(posedge clk);
        mon_pend = chk_issue;
        @(negedge clk);
        if (mon_pend) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: got 0x%08h want <no entry>", mem_rd);
            end else begin
                e = exp_q.pop_front();
                t = tol_q.pop_front();
                g = tag_q.pop_front();
                if ($isunknown(mem_rd))  ok = 1'b0;
                else if (t == 0)         ok = (mem_rd == e);
                else                     ok = (mem_rd + 32'(t) >= e) && (mem_rd <= e + 32'(t));
                if (!ok) begin
                    n_bad++;
                    $display("FAIL rd%0d: got 0x%08h want 0x%08h (tol %0d)", g, mem_rd, e, t);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] e, input int t);
        exp_q.push_back(e);
        tol_q.push_back(t);
        tag_q.push_back(rd_no);
        rd_no++;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] f, input logic [31:0] e, input int t);
        mem_wen = 1'b0; mem_ra = a; mem_funct3 = f;
        push_exp(e, t);
        chk_issue = 1'b1;
        @(negedge clk);
        chk_issue = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        mem_wen = 1'b1; mem_wa = a; mem_wd = d; mem_funct3 = f; mem_ra = 32'h0;
        chk_issue = 1'b0;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        mem_wen = 1'b1; mem_wa = a; mem_wd = d; mem_ra = a; mem_funct3 = F_W;
        push_exp(e, 0);
        chk_issue = 1'b1;
        @(negedge clk);
        chk_issue = 1'b0;
        mem_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_wen = 1'b0; mem_ra = 32'h0; mem_funct3 = F_W; chk_issue = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rst(input logic w, input logic [31:0] a, input logic [31:0] d);
        reset_n = 1'b0;
        mem_wen = w; mem_wa = a; mem_wd = d; mem_funct3 = F_W; mem_ra = 32'h20;
        push_exp(32'h0, 0);
        chk_issue = 1'b1;
        @(negedge clk);
        chk_issue = 1'b0;
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_err", {31'h0, misaligned_err}, 32'h0);
        reset_n = 1'b1;
        mem_wen = 1'b0;
    endtask

    initial begin
        bit wrapped;
        @(negedge clk);
        rst(1'b0, 32'h0, 32'h0);

        wr(32'h0, F_W, 32'h8badf00d);
        rd(32'h0, F_W, 32'h8badf00d, 0);
        rd(32'h3, F_B, 32'hffffff8b, 0);
        rd(32'h3, F_BU, 32'h0000008b, 0);
        rd(32'h2, F_H, 32'hffff8bad, 0);
        rd(32'h0, F_HU, 32'h0000f00d, 0);

        wr(32'h10, F_W, 32'h11223344);
        wr(32'h12, F_B, 32'h000000aa);
        rd(32'h10, F_W, 32'h11aa3344, 0);
        rd(32'h12, F_H, 32'h000011aa, 0);
        wr(32'h12, F_H, 32'h12348001);
        rd(32'h10, F_W, 32'h80013344, 0);
        rd(32'h12, F_H, 32'hffff8001, 0);
        rd(32'h11, F_BU, 32'h00000033, 0);

        wr(32'h20, F_W, 32'h5);
        rw(32'h20, 32'h9, 32'h5);
        rd(32'h20, F_W, 32'h9, 0);

        check("err_clear", {31'h0, misaligned_err}, 32'h0);
        wr(32'h22, F_W, 32'hdeadbeef);
        check("err_set", {31'h0, misaligned_err}, 32'h1);
        rd(32'h20, F_W, 32'h9, 0);
        rd(32'h22, F_W, 32'h0, 0);
        rd(32'h21, F_H, 32'h0, 0);

        wr(32'h30, F_W, 32'h0);
        rst(1'b1, 32'h30, 32'hffffffff);
        rd(32'h30, F_W, 32'h0, 0);

        wr(32'hfffffffc, F_B, 32'h123456a5);
        check("leds_sb", {24'h0, leds}, 32'h000000a5);
        rd(32'hfffffffc, F_W, 32'h000000a5, 0);
        rd(32'hfffffffc, F_B, 32'hffffffa5, 0);
        wr(32'hfffffffd, F_B, 32'h00000077);
        check("leds_lane1", {24'h0, leds}, 32'h000000a5);
        wr(32'hfffffff8, F_W, 32'h12345678);
        rd(32'hfffffff8, F_W, 32'h0, 0);
        rd(32'h10000000, F_W, 32'h0, 0);
        check("err_unmapped", {31'h0, misaligned_err}, 32'h0);

        rst(1'b0, 32'h0, 32'h0);
        idle(2000);
        rd(32'hfffffff4, F_W, 32'd1000, 1);
        idle(2008);
        rd(32'hfffffff8, F_W, 32'd2, 0);

        force dut.micros = 32'hffffffff;
        @(negedge clk);
        release dut.micros;
        wrapped = 1'b0;
        for (int i = 0; i < 8 && !wrapped; i++) begin
            @(negedge clk);
            if (dut.micros == 32'h0) wrapped = 1'b1;
        end
        check("micros_wrap", {31'h0, wrapped}, 32'h1);

        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
